axi_sp_mem_bridge: RTL

- AXI4 slave endpoint that consumes the AXI_BUS Slave-side signal set and drives a single-port synchronous SRAM with 1-cycle read latency.
- Sits directly downstream of the AXI_BUS interface, on-chip instruction and data memories hang off it.
- Serves one transaction at a time, read or write. Supports FIXED and INCR bursts up to 256 beats.

---
 rtl/axi_sp_mem_bridge_if.sv | 67 ++++++
 rtl/axi_sp_mem_bridge.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/axi_sp_mem_bridge_if.sv
// AXI4 address/data/response channel bundle between a master and the
// single-port memory bridge.
interface axi_sp_mem_bridge_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10
);
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic [AXI_ID_WIDTH-1:0]     aw_id;

    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic [AXI_ID_WIDTH-1:0]     ar_id;

    logic                        w_valid;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic                        w_ready;

    logic                        r_valid;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic                        r_ready;

    logic                        b_valid;
    logic [1:0]                  b_resp;
    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic                        b_ready;

    modport master (
        output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id,
        input  aw_ready,
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id,
        input  ar_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  r_valid, r_data, r_resp, r_last, r_id,
        output r_ready,
        input  b_valid, b_resp, b_id,
        output b_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id,
        output aw_ready,
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id,
        output ar_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output r_valid, r_data, r_resp, r_last, r_id,
        input  r_ready,
        output b_valid, b_resp, b_id,
        input  b_ready
    );
endinterface

// File: rtl/axi_sp_mem_bridge.sv
// AXI4 slave that serves one read or write burst at a time onto a single-port
// synchronous SRAM with one cycle of read latency.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | arbitrate AR vs AW, latch the winning request
// ST_READ  | issue memory reads, stream beats out through the R channel
// ST_WRITE | pass each accepted W beat straight to the memory
// ST_WRESP | hold the write response until B is accepted
module axi_sp_mem_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int MEM_ADDR_WIDTH = 13
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    axi_sp_mem_bridge_if.slave            axi,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
    output logic [AXI_DATA_WIDTH/8-1:0]   mem_be,
    output logic [AXI_DATA_WIDTH-1:0]     mem_wdata,
    input  logic [AXI_DATA_WIDTH-1:0]     mem_rdata
);
    localparam int BE  = AXI_DATA_WIDTH / 8;
    localparam int OFS = $clog2(BE);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_WRESP} state_e;

    state_e                      state_q, state_d;
    logic                        prio_q, prio_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                  len_q, len_d;
    logic [2:0]                  size_q, size_d;
    logic [1:0]                  burst_q, burst_d;
    logic [AXI_ID_WIDTH-1:0]     id_q, id_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic                        done_q, done_d;
    logic                        rvalid_q, rvalid_d;
    logic                        rhold_q, rhold_d;
    logic                        rlast_q, rlast_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [2:0]                  step_sh;
    logic [AXI_ADDR_WIDTH-1:0]   addr_step;
    logic [AXI_ADDR_WIDTH-1:0]   next_addr;
    logic                        unused_w_last;

    assign unused_w_last = axi.w_last;

    // WRAP bursts advance like INCR; only FIXED (00) holds the address.
    assign step_sh   = (size_q > 3'(OFS)) ? 3'(OFS) : size_q;
    assign addr_step = AXI_ADDR_WIDTH'(1) << step_sh;
    assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + addr_step;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= ST_IDLE;
            prio_q   <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rhold_q  <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
            rhold_q  <= rhold_d;
            rlast_q  <= rlast_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        burst_d      = burst_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        rvalid_d     = rvalid_q;
        rhold_d      = rhold_q;
        rlast_d      = rlast_q;
        rdata_d      = rdata_q;
        axi.ar_ready = 1'b0;
        axi.aw_ready = 1'b0;
        axi.w_ready  = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_be       = '0;
        mem_wdata    = '0;

        case (state_q)
            ST_IDLE: begin
                if (axi.ar_valid && (!axi.aw_valid || !prio_q)) begin
                    axi.ar_ready = 1'b1;
                    addr_d       = axi.ar_addr;
                    len_d        = axi.ar_len;
                    size_d       = axi.ar_size;
                    burst_d      = axi.ar_burst;
                    id_d         = axi.ar_id;
                    cnt_d        = '0;
                    done_d       = 1'b0;
                    state_d      = ST_READ;
                    if (axi.aw_valid) prio_d = 1'b1;
                end else if (axi.aw_valid) begin
                    axi.aw_ready = 1'b1;
                    addr_d       = axi.aw_addr;
                    len_d        = axi.aw_len;
                    size_d       = axi.aw_size;
                    burst_d      = axi.aw_burst;
                    id_d         = axi.aw_id;
                    cnt_d        = '0;
                    state_d      = ST_WRITE;
                    if (axi.ar_valid) prio_d = 1'b0;
                end
            end
            ST_READ: begin
                // Fresh SRAM data is forwarded directly; it is captured only
                // when the beat stalls so r_data stays stable under back-pressure.
                if (rvalid_q && axi.r_ready) begin
                    rvalid_d = 1'b0;
                    rhold_d  = 1'b0;
                    if (rlast_q) state_d = ST_IDLE;
                end else if (rvalid_q && !rhold_q) begin
                    rhold_d = 1'b1;
                    rdata_d = mem_rdata;
                end
                if (!done_q && (!rvalid_q || axi.r_ready)) begin
                    mem_req  = 1'b1;
                    rvalid_d = 1'b1;
                    rhold_d  = 1'b0;
                    rlast_d  = (cnt_q == len_q);
                    done_d   = (cnt_q == len_q);
                    cnt_d    = cnt_q + 8'd1;
                    addr_d   = next_addr;
                end
            end
            ST_WRITE: begin
                axi.w_ready = 1'b1;
                if (axi.w_valid) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_be    = axi.w_strb;
                    mem_wdata = axi.w_data;
                    addr_d    = next_addr;
                    cnt_d     = cnt_q + 8'd1;
                    if (cnt_q == len_q) state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (axi.b_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr    = mem_req ? addr_q[MEM_ADDR_WIDTH+OFS-1:OFS] : '0;

    assign axi.r_valid = rvalid_q;
    assign axi.r_data  = rvalid_q ? (rhold_q ? rdata_q : mem_rdata) : '0;
    assign axi.r_last  = rvalid_q & rlast_q;
    assign axi.r_resp  = 2'b00;
    assign axi.r_id    = rvalid_q ? id_q : '0;

    assign axi.b_valid = (state_q == ST_WRESP);
    assign axi.b_resp  = 2'b00;
    assign axi.b_id    = (state_q == ST_WRESP) ? id_q : '0;
endmodule
